// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT output collector: FSM encoding and the
// coefficient reduction / natural-order address helpers.
package ntt_pkg;

  localparam int unsigned PKG_W = 64;
  localparam int unsigned IDX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_COLLECT   = 2'd2,
    ST_DRAIN     = 2'd3
  } coll_state_e;

  // Single conditional subtraction; valid for inputs in [0, 2q).
  function automatic logic [PKG_W-1:0] coef_reduce(input logic [PKG_W-1:0] x,
                                                   input logic [PKG_W-1:0] q);
    return (x >= q) ? (x - q) : x;
  endfunction

  // Even stream indices fill the lower half, odd ones the upper half.
  function automatic logic [IDX_W-1:0] coef_addr(input logic [IDX_W-1:0] j,
                                                 input logic [3:0]       depth);
    logic [IDX_W-1:0] half;
    half = IDX_W'(1) << (depth - 4'd1);
    return (j >> 1) + (j[0] ? half : IDX_W'(0));
  endfunction

endpackage

// File: rtl/ntt_coef_buffer.sv
// Coefficient store: NUM_PE write ports, one registered read port.
// Memory array is not reset; only the read register is.
module ntt_coef_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NUM_PE = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_PE-1:0]              wr_en_i,
  input  logic [NUM_PE-1:0][ADDR_W-1:0]  wr_addr_i,
  input  logic [NUM_PE-1:0][DATA_W-1:0]  wr_data_i,
  input  logic                           rd_en_i,
  input  logic [ADDR_W-1:0]              rd_addr_i,
  output logic [DATA_W-1:0]              rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    for (int unsigned l = 0; l < NUM_PE; l++) begin
      if (wr_en_i[l]) mem_q[wr_addr_i[l]] <= wr_data_i[l];
    end
  end

  // Read data holds when rd_en_i is low, which gives the stall behaviour.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ntt_dout_collector.sv
// Collects NTT lane output, reduces mod q, reorders into natural order and
// streams the ring back out with a valid/ready handshake.
module ntt_dout_collector
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_DEPTH = 10,
  parameter int unsigned NUM_PE    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [3:0]               ring_depth,
  input  logic [DATA_W-1:0]        q,
  input  logic                     done,
  input  logic                     dout_valid,
  input  logic [NUM_PE*DATA_W-1:0] dout,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     collect_done
);

  localparam int unsigned AW = MAX_DEPTH;
  localparam int unsigned CW = MAX_DEPTH + 1;

  coll_state_e state_q, state_d;
  logic [3:0]        depth_q, depth_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              collect_done_q, collect_done_d;
  logic              busy_q, busy_d;

  logic [CW-1:0]                 n_c;
  logic [NUM_PE-1:0]             wr_en_c;
  logic [NUM_PE-1:0][AW-1:0]     wr_addr_c;
  logic [NUM_PE-1:0][DATA_W-1:0] wr_data_c;
  logic                          rd_en_c;
  logic [AW-1:0]                 rd_addr_c;

  assign n_c = CW'(1) << depth_q;

  // Per-lane write path; lanes past n are dropped.
  always_comb begin
    for (int unsigned l = 0; l < NUM_PE; l++) begin
      wr_en_c[l]   = (state_q == ST_COLLECT) && dout_valid && ((wr_cnt_q + CW'(l)) < n_c);
      wr_addr_c[l] = AW'(coef_addr(IDX_W'(wr_cnt_q + CW'(l)), depth_q));
      wr_data_c[l] = DATA_W'(coef_reduce(PKG_W'(dout[l*DATA_W +: DATA_W]), PKG_W'(q_q)));
    end
  end

  always_comb begin
    state_d        = state_q;
    depth_d        = depth_q;
    q_d            = q_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    out_valid_d    = out_valid_q;
    collect_done_d = 1'b0;
    rd_en_c        = 1'b0;
    rd_addr_c      = AW'(rd_cnt_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_WAIT_DONE;
          depth_d  = ring_depth;
          q_d      = q;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      ST_WAIT_DONE: begin
        if (done) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (dout_valid) begin
          wr_cnt_d = wr_cnt_q + CW'(NUM_PE);
          if ((wr_cnt_q + CW'(NUM_PE)) >= n_c) begin
            state_d        = ST_DRAIN;
            collect_done_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Issue a read whenever the output slot is empty or being consumed.
        if (!out_valid_q || out_ready) begin
          if (rd_cnt_q < n_c) begin
            rd_en_c     = 1'b1;
            rd_cnt_d    = rd_cnt_q + CW'(1);
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d        = ST_IDLE;
      wr_cnt_d       = '0;
      rd_cnt_d       = '0;
      out_valid_d    = 1'b0;
      collect_done_d = 1'b0;
      rd_en_c        = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      depth_q        <= '0;
      q_q            <= '0;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      out_valid_q    <= 1'b0;
      collect_done_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      depth_q        <= depth_d;
      q_q            <= q_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      out_valid_q    <= out_valid_d;
      collect_done_q <= collect_done_d;
      busy_q         <= busy_d;
    end
  end

  ntt_coef_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (AW),
    .NUM_PE (NUM_PE)
  ) u_buf (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (wr_addr_c),
    .wr_data_i (wr_data_c),
    .rd_en_i   (rd_en_c),
    .rd_addr_i (rd_addr_c),
    .rd_data_o (out_data)
  );

  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign collect_done = collect_done_q;

endmodule

// File: tb/tb_ntt_dout_collector.sv
// Bench for ntt_dout_collector: three instances (NUM_PE = 1, 2, 4) sharing one
// stimulus bus, selected by sel, checked against a natural-order model.
module tb_ntt_dout_collector;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic start, abort, done, dout_valid, out_ready;
  logic [3:0]      ring_depth;
  logic [DW-1:0]   q;
  logic [4*DW-1:0] dout;
  int              sel;

  logic [2:0]    ov, bz, cd;
  logic [DW-1:0] od [3];

  int errors = 0;
  int checks = 0;
  int cd_cnt = 0;

  logic [DW-1:0] xs   [1024];
  logic [DW-1:0] expv [1024];
  logic [DW-1:0] got  [1024];

  always #5 clk = ~clk;

  ntt_dout_collector #(.DATA_W(DW), .MAX_DEPTH(10), .NUM_PE(1)) u_pe1 (
    .clk(clk), .reset(reset), .start(start && sel == 0), .abort(abort && sel == 0),
    .ring_depth(ring_depth), .q(q), .done(done && sel == 0),
    .dout_valid(dout_valid && sel == 0), .dout(dout[DW-1:0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready && sel == 0),
    .busy(bz[0]), .collect_done(cd[0]));

  ntt_dout_collector #(.DATA_W(DW), .MAX_DEPTH(10), .NUM_PE(2)) u_pe2 (
    .clk(clk), .reset(reset), .start(start && sel == 1), .abort(abort && sel == 1),
    .ring_depth(ring_depth), .q(q), .done(done && sel == 1),
    .dout_valid(dout_valid && sel == 1), .dout(dout[2*DW-1:0]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready && sel == 1),
    .busy(bz[1]), .collect_done(cd[1]));

  ntt_dout_collector #(.DATA_W(DW), .MAX_DEPTH(10), .NUM_PE(4)) u_pe4 (
    .clk(clk), .reset(reset), .start(start && sel == 2), .abort(abort && sel == 2),
    .ring_depth(ring_depth), .q(q), .done(done && sel == 2),
    .dout_valid(dout_valid && sel == 2), .dout(dout),
    .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready && sel == 2),
    .busy(bz[2]), .collect_done(cd[2]));

  always @(negedge clk) if (cd[sel] === 1'b1) cd_cnt++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lanes(input int s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  // Natural order: even j land in the first half, odd j in the second half.
  task automatic build_model(input int depth, input logic [DW-1:0] qv);
    int n;
    n = 1 << depth;
    for (int j = 0; j < n; j++) begin
      logic [DW-1:0] r;
      r = (xs[j] >= qv) ? xs[j] - qv : xs[j];
      if (j % 2 == 0) expv[j / 2] = r;
      else            expv[n / 2 + j / 2] = r;
    end
  endtask

  task automatic gen_data(input int depth, input logic [DW-1:0] qv, input int xkind);
    for (int j = 0; j < (1 << depth); j++) begin
      case (xkind)
        0:       xs[j] = qv + DW'(j);
        1:       xs[j] = qv - 1;
        default: xs[j] = $urandom_range(0, 2 * qv - 1);
      endcase
    end
  endtask

  task automatic arm(input int depth, input logic [DW-1:0] qv);
    ring_depth = 4'(depth);
    q          = qv;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    ring_depth = 4'($urandom_range(2, 10));
    q          = $urandom;
  endtask

  task automatic fire_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic feed(input int ncoef, input int gapmax);
    int npe;
    npe = lanes(sel);
    for (int b = 0; b < ncoef / npe; b++) begin
      int gaps;
      gaps = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
      dout_valid = 1'b0;
      for (int g = 0; g < gaps; g++) begin
        dout = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
      dout_valid = 1'b1;
      dout = {$urandom, $urandom, $urandom, $urandom};
      for (int l = 0; l < npe; l++) dout[l*DW +: DW] = xs[b * npe + l];
      tick();
    end
    dout_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int mode);
    int k, cyc;
    bit stalled, rdy;
    logic [DW-1:0] held;
    check("drain_entry_collect_done", cd[sel], 1);
    check("drain_entry_valid", ov[sel], 0);
    out_ready = 1'b0;
    tick();
    check("first_valid", ov[sel], 1);
    k = 0; cyc = 0; stalled = 0; held = '0;
    while (k < n && cyc < 8 * n + 50) begin
      if (stalled) begin
        check("stall_valid", ov[sel], 1);
        check("stall_data", od[sel], held);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (ov[sel] && rdy) begin
        got[k] = od[sel];
        check($sformatf("word[%0d]", k), od[sel], expv[k]);
        k++;
        stalled = 0;
      end else if (ov[sel]) begin
        stalled = 1;
        held    = od[sel];
      end else begin
        stalled = 0;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("word_count", k, n);
    if (mode == 0) check("sustained_rate", cyc, n);
    check("end_valid_low", ov[sel], 0);
    check("end_busy_low", bz[sel], 0);
  endtask

  task automatic run_full(input int s, input int depth, input logic [DW-1:0] qv,
                          input int xkind, input int mode, input int gapmax);
    sel = s;
    gen_data(depth, qv, xkind);
    build_model(depth, qv);
    cd_cnt = 0;
    arm(depth, qv);
    check("armed_busy", bz[sel], 1);
    fire_done();
    feed(1 << depth, gapmax);
    drain(1 << depth, mode);
    check("collect_done_once", cd_cnt, 1);
  endtask

  typedef struct {
    int            s;
    int            depth;
    logic [DW-1:0] qv;
    int            xkind;
    int            mode;
    int            gapmax;
    bit            has_pts;
    int            idx [3];
    logic [DW-1:0] val [3];
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{0, 8, 7681, 0, 0, 0, 1, '{0, 128, 255}, '{0, 1, 255}};
    tbl[1] = '{1, 10, 12289, 1, 0, 0, 1, '{0, 511, 1023}, '{12288, 12288, 12288}};
    tbl[2] = '{0, 8, 7681, 2, 1, 2, 0, '{0, 0, 0}, '{0, 0, 0}};
    tbl[3] = '{2, 2, 17, 0, 0, 0, 1, '{1, 2, 3}, '{2, 1, 3}};
    tbl[4] = '{2, 6, 3329, 2, 2, 3, 0, '{0, 0, 0}, '{0, 0, 0}};
    tbl[5] = '{1, 3, 97, 2, 2, 2, 0, '{0, 0, 0}, '{0, 0, 0}};
    tbl[6] = '{1, 8, 7681, 0, 1, 1, 1, '{0, 128, 255}, '{0, 1, 255}};

    sel = 0; reset = 1'b0;
    start = 0; abort = 0; done = 0; dout_valid = 0; out_ready = 0;
    ring_depth = '0; q = '0; dout = '0;
    tick(); tick();
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_busy[%0d]", s), bz[s], 0);
      check($sformatf("reset_valid[%0d]", s), ov[s], 0);
      check($sformatf("reset_data[%0d]", s), od[s], 0);
      check($sformatf("reset_cdone[%0d]", s), cd[s], 0);
    end
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_full(tbl[i].s, tbl[i].depth, tbl[i].qv, tbl[i].xkind, tbl[i].mode, tbl[i].gapmax);
      if (tbl[i].has_pts)
        for (int p = 0; p < 3; p++)
          check($sformatf("row%0d_word%0d", i, tbl[i].idx[p]), got[tbl[i].idx[p]], tbl[i].val[p]);
    end

    // Stray done/dout_valid in IDLE; start+done together; start again in WAIT_DONE.
    sel = 0;
    dout_valid = 1'b1; done = 1'b1; dout = {4{32'h0000_0005}};
    tick(); tick();
    dout_valid = 1'b0; done = 1'b0;
    check("idle_ignore_busy", bz[0], 0);
    check("idle_ignore_valid", ov[0], 0);
    gen_data(3, 97, 2);
    build_model(3, 97);
    cd_cnt = 0;
    ring_depth = 4'd3; q = 97; start = 1'b1; done = 1'b1;
    tick();
    start = 1'b0; done = 1'b0;
    check("start_done_arms", bz[0], 1);
    dout_valid = 1'b1; dout = {4{32'd50}}; start = 1'b1; ring_depth = 4'd5; q = 11;
    tick(); tick();
    dout_valid = 1'b0; start = 1'b0;
    check("wait_done_busy", bz[0], 1);
    check("wait_done_no_cdone", cd_cnt, 0);
    fire_done();
    feed(8, 1);
    drain(8, 2);
    check("seq_a_cdone_once", cd_cnt, 1);

    // Reset asserted mid-collection, then a fresh complete run.
    sel = 0;
    gen_data(10, 7681, 2);
    arm(10, 7681);
    fire_done();
    feed(100, 0);
    reset = 1'b0;
    #1;
    check("midrun_reset_busy", bz[0], 0);
    check("midrun_reset_valid", ov[0], 0);
    check("midrun_reset_cdone", cd[0], 0);
    check("midrun_reset_data", od[0], 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("post_reset_idle", bz[0], 0);
    run_full(0, 10, 7681, 2, 2, 1);

    // Abort in the middle of DRAIN, then a fresh run.
    sel = 1;
    gen_data(4, 257, 2);
    arm(4, 257);
    fire_done();
    feed(16, 0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    abort = 1'b1; out_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_valid", ov[1], 0);
    check("abort_busy", bz[1], 0);
    tick();
    check("abort_stays_idle", bz[1], 0);
    run_full(1, 4, 257, 2, 1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
